// File: rtl/ccu_snoop_resp_merge.sv
// Fans one AC snoop out to the masked cached masters, merges their CR responses into one, then
// forwards a single CD burst and drains the others. One snoop transaction in flight at a time.
module ccu_snoop_resp_merge #(
  parameter int unsigned NumSnp      = 4,
  parameter int unsigned AcWidth     = 48,
  parameter int unsigned CdDataWidth = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                ac_valid_i,
  output logic                                ac_ready_o,
  input  logic [AcWidth-1:0]                  ac_i,
  input  logic [NumSnp-1:0]                   mask_i,
  output logic                                cr_valid_o,
  input  logic                                cr_ready_i,
  output logic [4:0]                          cr_resp_o,
  output logic                                cd_valid_o,
  input  logic                                cd_ready_i,
  output logic [CdDataWidth:0]                cd_o,
  output logic [NumSnp-1:0]                   snp_ac_valid_o,
  input  logic [NumSnp-1:0]                   snp_ac_ready_i,
  output logic [AcWidth-1:0]                  snp_ac_o,
  input  logic [NumSnp-1:0]                   snp_cr_valid_i,
  output logic [NumSnp-1:0]                   snp_cr_ready_o,
  input  logic [NumSnp*5-1:0]                 snp_cr_resp_i,
  input  logic [NumSnp-1:0]                   snp_cd_valid_i,
  output logic [NumSnp-1:0]                   snp_cd_ready_o,
  input  logic [NumSnp*(CdDataWidth+1)-1:0]   snp_cd_i
);

  // A CD beat is {data, last}; last sits in bit 0.
  localparam int CdWidth = int'(CdDataWidth) + 1;
  localparam int SelW    = (NumSnp > 1) ? $clog2(NumSnp) : 1;
  localparam int RespDt  = 0;
  localparam int RespPd  = 2;

  typedef enum logic [2:0] {StIdle, StBcast, StCollect, StResp, StData} state_e;

  state_e               state_q, state_d;
  logic [AcWidth-1:0]   ac_q, ac_d;
  logic [NumSnp-1:0]    mask_q, mask_d;
  logic [NumSnp-1:0]    ac_done_q, ac_done_d;
  logic [NumSnp-1:0]    cr_done_q, cr_done_d;
  logic [NumSnp-1:0]    cd_done_q, cd_done_d;
  logic [NumSnp*5-1:0]  resp_q, resp_d;

  logic [NumSnp-1:0]    ac_hs, cr_hs, cd_last_hs;
  logic [NumSnp-1:0]    dt_vec, pd_dt_vec;
  logic [4:0]           merged;
  logic [SelW-1:0]      sel;

  assign snp_ac_o = ac_q;
  assign ac_hs    = snp_ac_valid_o & snp_ac_ready_i;
  assign cr_hs    = snp_cr_ready_o & snp_cr_valid_i;

  always_comb begin
    cd_last_hs = '0;
    for (int i = 0; i < int'(NumSnp); i++) begin
      cd_last_hs[i] = snp_cd_valid_i[i] & snp_cd_ready_o[i] & snp_cd_i[i*CdWidth];
    end
  end

  // Merge is derived purely from registers, so it holds steady while cr_valid_o waits.
  always_comb begin
    merged    = '0;
    dt_vec    = '0;
    pd_dt_vec = '0;
    for (int i = 0; i < int'(NumSnp); i++) begin
      if (mask_q[i]) begin
        merged = merged | resp_q[i*5 +: 5];
      end
      dt_vec[i]    = mask_q[i] & resp_q[i*5 + RespDt];
      pd_dt_vec[i] = dt_vec[i] & resp_q[i*5 + RespPd];
    end
  end

  // Dirty data wins over clean; ties go to the lowest index.
  always_comb begin
    sel = '0;
    if (|pd_dt_vec) begin
      for (int i = int'(NumSnp) - 1; i >= 0; i--) begin
        if (pd_dt_vec[i]) sel = SelW'(i);
      end
    end else begin
      for (int i = int'(NumSnp) - 1; i >= 0; i--) begin
        if (dt_vec[i]) sel = SelW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ac_q      <= '0;
      mask_q    <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      cd_done_q <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      ac_q      <= ac_d;
      mask_q    <= mask_d;
      ac_done_q <= ac_done_d;
      cr_done_q <= cr_done_d;
      cd_done_q <= cd_done_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    mask_d    = mask_q;
    ac_done_d = ac_done_q;
    cr_done_d = cr_done_q;
    cd_done_d = cd_done_q;
    resp_d    = resp_q;
    unique case (state_q)
      StIdle: begin
        if (ac_valid_i) begin
          ac_d      = ac_i;
          mask_d    = mask_i;
          ac_done_d = '0;
          cr_done_d = '0;
          cd_done_d = '0;
          resp_d    = '0;
          state_d   = (mask_i == '0) ? StResp : StBcast;
        end
      end
      StBcast: begin
        ac_done_d = ac_done_q | ac_hs;
        if ((mask_q & ~ac_done_d) == '0) state_d = StCollect;
      end
      StCollect: begin
        for (int i = 0; i < int'(NumSnp); i++) begin
          if (cr_hs[i]) resp_d[i*5 +: 5] = snp_cr_resp_i[i*5 +: 5];
        end
        cr_done_d = cr_done_q | cr_hs;
        if ((mask_q & ~cr_done_d) == '0) state_d = StResp;
      end
      StResp: begin
        if (cr_ready_i) state_d = (dt_vec == '0) ? StIdle : StData;
      end
      StData: begin
        cd_done_d = cd_done_q | cd_last_hs;
        if ((dt_vec & ~cd_done_d) == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ac_ready_o     = 1'b0;
    cr_valid_o     = 1'b0;
    cr_resp_o      = '0;
    cd_valid_o     = 1'b0;
    cd_o           = '0;
    snp_ac_valid_o = '0;
    snp_cr_ready_o = '0;
    snp_cd_ready_o = '0;
    unique case (state_q)
      StIdle:    ac_ready_o = 1'b1;
      StBcast:   snp_ac_valid_o = mask_q & ~ac_done_q;
      StCollect: snp_cr_ready_o = mask_q & ~cr_done_q;
      StResp: begin
        cr_valid_o = 1'b1;
        cr_resp_o  = merged;
      end
      StData: begin
        // Everyone with data is drained; the selected master is steered to the controller.
        snp_cd_ready_o = dt_vec & ~cd_done_q;
        if (!cd_done_q[sel]) begin
          cd_valid_o          = snp_cd_valid_i[sel];
          cd_o                = snp_cd_i[int'(sel)*CdWidth +: CdWidth];
          snp_cd_ready_o[sel] = cd_ready_i;
        end
      end
      default: ;
    endcase
  end

  cr_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cr_valid_o && !cr_ready_i) |=> (cr_valid_o && $stable(cr_resp_o)));

  unmasked_quiet_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((snp_ac_valid_o | snp_cr_ready_o | snp_cd_ready_o) & ~mask_q) == '0);

  ac_ready_idle_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ac_ready_o == (state_q == StIdle));

endmodule
